// File: rtl/uart_rx_ovs_if.sv
// Receive-side stream interface of uart_rx_ovs: payload, per-frame flags,
// event pulses and the valid/ready handshake towards the consumer.
`timescale 1ns/1ps
interface uart_rx_ovs_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 overrun;

  // Receiver side: produces the frame, consumes ready
  modport master (
    output data, valid, parity_err, frame_err, break_det, overrun,
    input  ready
  );

  // Consumer side: takes the frame, produces ready
  modport slave (
    input  data, valid, parity_err, frame_err, break_det, overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx_ovs.sv
// Parametrised oversampling UART receiver: 2-flop input synchroniser,
// 3-sample majority vote around mid-bit, optional parity, 1 or 2 stop bits,
// break detection and a one-entry output register with overrun reporting.
`timescale 1ns/1ps
module uart_rx_ovs #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_i,
  uart_rx_ovs_if.master rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MIDM1_C    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] MID_C      = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] MIDP1_C    = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] LAST_C     = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST_C = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST_C = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_PARITY     = 3'd3,
    S_STOP       = 3'd4,
    S_BREAK_WAIT = 3'd5
  } state_t;

  // Majority of three samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent for payload d
  function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
    exp_parity = (PARITY == 2) ? ~(^d) : (^d);
  endfunction

  logic                 rx_meta_q, rx_s_q;
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic                 stop_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_bit_q, acc_perr_q, acc_ferr_q, stop0_zero_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, parity_err_q, frame_err_q, break_det_q, overrun_q;

  logic vote_d, commit_d, first_stop_zero_d, break_d;

  // Two-flop synchroniser; idle-high reset so no spurious start is seen
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Vote resolution and end-of-frame decode (commit happens at MID+1 of the last stop bit)
  always_comb begin
    vote_d            = maj3(samp_q[0], samp_q[1], rx_s_q);
    commit_d          = 1'b0;
    first_stop_zero_d = 1'b0;
    if ((state_q == S_STOP) && (cnt_q == MIDP1_C) && (stop_q == STOP_LAST_C)) begin
      commit_d = 1'b1;
    end else begin
      commit_d = 1'b0;
    end
    if (stop_q == 1'b0) begin
      first_stop_zero_d = ~vote_d;
    end else begin
      first_stop_zero_d = stop0_zero_q;
    end
    break_d = commit_d && (shreg_q == {DATA_BITS{1'b0}}) &&
              ((PARITY == 0) || !par_bit_q) && first_stop_zero_d;
  end

  // Frame state machine, bit timing and the one-entry output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      bit_q        <= {BW{1'b0}};
      stop_q       <= 1'b0;
      samp_q       <= 2'b11;
      shreg_q      <= {DATA_BITS{1'b0}};
      par_bit_q    <= 1'b0;
      acc_perr_q   <= 1'b0;
      acc_ferr_q   <= 1'b0;
      stop0_zero_q <= 1'b0;
      data_q       <= {DATA_BITS{1'b0}};
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q   <= 1'b0;
      break_det_q <= break_d;
      if (cnt_q == MIDM1_C) samp_q[0] <= rx_s_q;
      if (cnt_q == MID_C)   samp_q[1] <= rx_s_q;
      cnt_q <= (cnt_q == LAST_C) ? {CW{1'b0}} : cnt_q + CW'(1);

      case (state_q)
        S_IDLE: begin
          cnt_q <= {CW{1'b0}};
          if (!rx_s_q) begin
            state_q      <= S_START;
            bit_q        <= {BW{1'b0}};
            stop_q       <= 1'b0;
            par_bit_q    <= 1'b0;
            acc_perr_q   <= 1'b0;
            acc_ferr_q   <= 1'b0;
            stop0_zero_q <= 1'b0;
          end
        end
        S_START: begin
          if ((cnt_q == MIDP1_C) && vote_d) begin
            state_q <= S_IDLE;
          end else if (cnt_q == LAST_C) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q == MIDP1_C) shreg_q <= {vote_d, shreg_q[DATA_BITS-1:1]};
          if (cnt_q == LAST_C) begin
            if (bit_q == BIT_LAST_C) begin
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (cnt_q == MIDP1_C) begin
            par_bit_q  <= vote_d;
            acc_perr_q <= (vote_d != exp_parity(shreg_q));
          end
          if (cnt_q == LAST_C) state_q <= S_STOP;
        end
        S_STOP: begin
          if (cnt_q == MIDP1_C) begin
            if (!vote_d) acc_ferr_q <= 1'b1;
            if (stop_q == 1'b0) stop0_zero_q <= ~vote_d;
          end
          // Early resync: leave the last stop bit at MID+1 so the next start edge is caught
          if (commit_d) begin
            state_q <= break_d ? S_BREAK_WAIT : S_IDLE;
          end else if (cnt_q == LAST_C) begin
            stop_q <= 1'b1;
          end
        end
        S_BREAK_WAIT: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (commit_d) begin
        if (!valid_q || rx_if.ready) begin
          data_q       <= break_d ? {DATA_BITS{1'b0}} : shreg_q;
          parity_err_q <= (PARITY != 0) ? acc_perr_q : 1'b0;
          frame_err_q  <= acc_ferr_q | ~vote_d | break_d;
          valid_q      <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_if.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.data       = data_q;
  assign rx_if.valid      = valid_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.break_det  = break_det_q;
  assign rx_if.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: default config (even parity), an odd-parity
// twin on the same line, and a 7N2 / 8x-clock instance.
`timescale 1ns/1ps
module tb_uart_rx_ovs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic ready_a = 1'b0;
  logic ready_b = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  uart_rx_ovs_if #(.DATA_BITS(8)) if_a ();
  uart_rx_ovs_if #(.DATA_BITS(8)) if_o ();
  uart_rx_ovs_if #(.DATA_BITS(7)) if_b ();
  assign if_a.ready = ready_a;
  assign if_o.ready = ready_a;
  assign if_b.ready = ready_b;

  uart_rx_ovs #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(1))
    dut_a (.clk_i(clk), .rst_i(rst), .rx_i(rx_a), .rx_if(if_a));
  uart_rx_ovs #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(1))
    dut_o (.clk_i(clk), .rst_i(rst), .rx_i(rx_a), .rx_if(if_o));
  uart_rx_ovs #(.DATA_BITS(7), .CLKS_PER_BIT(8), .PARITY(0), .STOP_BITS(2))
    dut_b (.clk_i(clk), .rst_i(rst), .rx_i(rx_b), .rx_if(if_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  logic       vp_a = 1'b0, vp_o = 1'b0, vp_b = 1'b0;
  int         rise_a = 0, rise_o = 0, rise_b = 0, vhigh_a = 0;
  int         rcyc_a = 0, rcyc_b = 0, bcyc_a = 0, brk_a = 0, ovr_a = 0;
  logic [7:0] cd_a = 8'h00;
  logic [6:0] cd_b = 7'h00;
  logic       cpe_a = 1'b0, cfe_a = 1'b0, cpe_o = 1'b0, cpe_b = 1'b0, cfe_b = 1'b0;
  always @(negedge clk) begin
    vp_a <= if_a.valid;
    vp_o <= if_o.valid;
    vp_b <= if_b.valid;
    if (if_a.valid === 1'b1) vhigh_a <= vhigh_a + 1;
    if (if_a.valid === 1'b1 && vp_a === 1'b0) begin
      rise_a <= rise_a + 1; rcyc_a <= cyc;
      cd_a <= if_a.data; cpe_a <= if_a.parity_err; cfe_a <= if_a.frame_err;
    end
    if (if_o.valid === 1'b1 && vp_o === 1'b0) begin
      rise_o <= rise_o + 1; cpe_o <= if_o.parity_err;
    end
    if (if_b.valid === 1'b1 && vp_b === 1'b0) begin
      rise_b <= rise_b + 1; rcyc_b <= cyc;
      cd_b <= if_b.data; cpe_b <= if_b.parity_err; cfe_b <= if_b.frame_err;
    end
    if (if_a.break_det === 1'b1) begin brk_a <= brk_a + 1; bcyc_a <= cyc; end
    if (if_a.overrun === 1'b1) ovr_a <= ovr_a + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive line A, 16 clocks per bit, optional one-cycle inverted glitch at line cycle gj
  task automatic drive_a(input logic [31:0] bits, input int nbits, input int gj, output int st);
    @(posedge clk); #1;
    st = cyc;
    for (int j = 0; j < nbits * 16; j++) begin
      rx_a = bits[j / 16] ^ (j == gj);
      @(posedge clk); #1;
    end
    rx_a = 1'b1;
  endtask

  // Drive line B, 8 clocks per bit; optional 2-cycle reset at line cycle rj aborts the frame
  task automatic drive_b(input logic [31:0] bits, input int nbits, input int rj, output int st);
    @(posedge clk); #1;
    st = cyc;
    for (int j = 0; j < nbits * 8; j++) begin
      if (j == rj) begin
        rx_b = 1'b1;
        rst  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst  = 1'b0;
        break;
      end
      rx_b = bits[j / 8];
      @(posedge clk); #1;
    end
    rx_b = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stp;
    int         glitch;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_pe_o;
  } vec_t;

  vec_t vecs [8];
  int st, st2, ra, ro, vh, bk, ov, rb;
  logic [31:0] fb;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, -1, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, -1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, -1, 8'h3C, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b1, -1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, -1, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h07, 1'b0, 1'b1, -1, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hA5, 1'b0, 1'b1, 73, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h3C, 1'b0, 1'b1, 25, 8'h3C, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid_a", {31'd0, if_a.valid}, 32'd0);
    check("rst_data_a", {24'd0, if_a.data}, 32'd0);
    check("rst_flags_a", {28'd0, if_a.parity_err, if_a.frame_err, if_a.break_det, if_a.overrun}, 32'd0);
    check("rst_valid_b", {31'd0, if_b.valid}, 32'd0);

    // Table of single frames on line A with ready held high
    ready_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = rise_a; ro = rise_o; vh = vhigh_a;
      fb = {21'd0, vecs[i].stp, vecs[i].par, vecs[i].d, 1'b0};
      drive_a(fb, 11, vecs[i].glitch, st);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_rise", i), rise_a - ra, 32'd1);
      check($sformatf("v%0d_data", i), {24'd0, cd_a}, {24'd0, vecs[i].exp_d});
      check($sformatf("v%0d_perr", i), {31'd0, cpe_a}, {31'd0, vecs[i].exp_pe});
      check($sformatf("v%0d_ferr", i), {31'd0, cfe_a}, {31'd0, vecs[i].exp_fe});
      check($sformatf("v%0d_lat", i), rcyc_a - st, 32'd173);
      check($sformatf("v%0d_vlen", i), vhigh_a - vh, 32'd1);
      check($sformatf("v%0d_rise_odd", i), rise_o - ro, 32'd1);
      check($sformatf("v%0d_perr_odd", i), {31'd0, cpe_o}, {31'd0, vecs[i].exp_pe_o});
    end

    // 3-cycle low pulse on idle line: no frame, then a clean frame follows
    ra = rise_a;
    @(posedge clk); #1 rx_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_no_valid", rise_a - ra, 32'd0);
    drive_a({21'd0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, -1, st);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("after_glitch_data", {24'd0, cd_a}, 32'h5A);
    check("after_glitch_lat", rcyc_a - st, 32'd173);

    // Break: line low for 20 bit times
    ra = rise_a; bk = brk_a;
    @(posedge clk); #1;
    st = cyc;
    rx_a = 1'b0;
    repeat (320) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("brk_pulses", brk_a - bk, 32'd1);
    check("brk_frames", rise_a - ra, 32'd1);
    check("brk_data", {24'd0, cd_a}, 32'd0);
    check("brk_ferr", {31'd0, cfe_a}, 32'd1);
    check("brk_lat", rcyc_a - st, 32'd173);
    check("brk_pulse_cyc", bcyc_a - st, 32'd173);
    bk = brk_a;
    drive_a({21'd0, 1'b1, 1'b0, 8'h55, 1'b0}, 11, -1, st);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_brk_data", {24'd0, cd_a}, 32'h55);
    check("post_brk_ferr", {31'd0, cfe_a}, 32'd0);
    check("post_brk_nobrk", brk_a - bk, 32'd0);

    // Overrun: second frame dropped while the first is held
    ready_a = 1'b0; ov = ovr_a;
    drive_a({21'd0, 1'b1, 1'b0, 8'h11, 1'b0}, 11, -1, st);
    drive_a({21'd0, 1'b1, 1'b0, 8'h22, 1'b0}, 11, -1, st);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("ovr_pulses", ovr_a - ov, 32'd1);
    check("ovr_data_held", {24'd0, if_a.data}, 32'h11);
    check("ovr_valid_held", {31'd0, if_a.valid}, 32'd1);
    @(posedge clk); #1 ready_a = 1'b1;
    @(posedge clk); #1 ready_a = 1'b0;
    @(negedge clk);
    check("ovr_drained", {31'd0, if_a.valid}, 32'd0);

    // Transfer in the commit cycle: new frame replaces the held one, no overrun
    drive_a({21'd0, 1'b1, 1'b0, 8'h11, 1'b0}, 11, -1, st);
    repeat (20) @(posedge clk);
    ov = ovr_a;
    fork
      drive_a({21'd0, 1'b1, 1'b0, 8'h22, 1'b0}, 11, -1, st2);
      begin
        @(posedge clk);
        repeat (172) @(posedge clk);
        #1 ready_a = 1'b1;
        @(posedge clk);
        #1 ready_a = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("swap_data", {24'd0, if_a.data}, 32'h22);
    check("swap_valid", {31'd0, if_a.valid}, 32'd1);
    check("swap_no_ovr", ovr_a - ov, 32'd0);
    @(posedge clk); #1 ready_a = 1'b1;

    // Alternate configuration: 7 data bits, no parity, 2 stop bits, 8 clocks/bit
    rb = rise_b;
    drive_b({22'd0, 1'b1, 1'b1, 7'h5A, 1'b0}, 10, -1, st);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("b_rise", rise_b - rb, 32'd1);
    check("b_data", {25'd0, cd_b}, 32'h5A);
    check("b_flags", {30'd0, cpe_b, cfe_b}, 32'd0);
    check("b_lat", rcyc_b - st, 32'd81);

    // Reset mid data bit 3 drops the partial frame
    rb = rise_b;
    drive_b({22'd0, 1'b1, 1'b1, 7'h2B, 1'b0}, 10, 37, st);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_valid", rise_b - rb, 32'd0);
    check("rst_mid_data_b", {25'd0, if_b.data}, 32'd0);
    check("rst_mid_outs_b", {27'd0, if_b.valid, if_b.parity_err, if_b.frame_err, if_b.break_det, if_b.overrun}, 32'd0);
    check("rst_mid_data_a", {24'd0, if_a.data}, 32'd0);
    rb = rise_b;
    drive_b({22'd0, 1'b1, 1'b1, 7'h33, 1'b0}, 10, -1, st);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("b_after_rst_rise", rise_b - rb, 32'd1);
    check("b_after_rst_data", {25'd0, cd_b}, 32'h33);
    check("b_after_rst_lat", rcyc_b - st, 32'd81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
